// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues valid/ready data-memory requests, aligns store
// data and strobes, extracts and extends load data, and registers the MEM/WB fields.
module mem_access_stage #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [XLEN-1:0]   dmem_addr,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [STRB_W-1:0] dmem_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_stall,
  output logic [XLEN-1:0]   wb_result,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              misalign_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              fault_q, fault_d;
  logic              wb_load;

  logic              memop;
  logic              misaligned;
  logic [1:0]        addr_lo;
  logic [XLEN-1:0]   rdata_shifted;
  logic [XLEN-1:0]   load_data;

  assign memop   = ex_mem_read | ex_mem_write;
  assign addr_lo = ex_alu_result[1:0];

  // Size 11 behaves as a word everywhere, so size[1] alone selects word handling.
  assign misaligned = memop &
                      (((ex_mem_size == 2'b01) & addr_lo[0]) |
                       (ex_mem_size[1] & (addr_lo != 2'b00)));

  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_addr      = {ex_alu_result[XLEN-1:2], 2'b00};
  assign dmem_we        = ex_mem_write;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    dmem_wdata = ex_rs2_data;
    dmem_wstrb = '0;
    unique case (ex_mem_size)
      2'b00: begin
        dmem_wdata = {4{ex_rs2_data[7:0]}};
        dmem_wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        dmem_wdata = {2{ex_rs2_data[15:0]}};
        dmem_wstrb = 4'b0011 << addr_lo;
      end
      default: begin
        dmem_wdata = ex_rs2_data;
        dmem_wstrb = 4'b1111;
      end
    endcase
    if (!ex_mem_write) dmem_wstrb = '0;
  end

  // Move the addressed lane down to bit 0, then extend to full width.
  assign rdata_shifted = dmem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = rdata_shifted;
    unique case (ex_mem_size)
      2'b00:   load_data = ex_mem_unsigned ? {24'b0, rdata_shifted[7:0]}
                                           : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_data = ex_mem_unsigned ? {16'b0, rdata_shifted[15:0]}
                                           : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    wb_load        = 1'b0;
    wb_result_d    = ex_alu_result;
    wb_rd_d        = ex_rd;
    wb_reg_write_d = ex_reg_write;
    fault_d        = 1'b0;
    mem_stall      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!memop) begin
          wb_load = 1'b1;
        end else if (misaligned) begin
          wb_load        = 1'b1;
          wb_reg_write_d = 1'b0;
          fault_d        = 1'b1;
        end else begin
          mem_stall = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_req_ready && ex_mem_write) begin
          wb_load = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_stall = 1'b1;
          if (dmem_req_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          wb_load     = 1'b1;
          wb_result_d = ex_mem_to_reg ? load_data : ex_alu_result;
          state_d     = S_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wb_result_q    <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (wb_load) begin
        wb_result_q    <= wb_result_d;
        wb_rd_q        <= wb_rd_d;
        wb_reg_write_q <= wb_reg_write_d;
      end
    end
  end

  assign wb_result      = wb_result_q;
  assign wb_rd          = wb_rd_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_alu_result, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, misalign_fault;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .misalign_fault(misalign_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic rd_en, input logic wr_en, input logic m2r,
                        input logic [1:0] size, input logic uns);
    ex_alu_result = alu;  ex_rs2_data = rs2; ex_rd = rd;
    ex_reg_write = rw;    ex_mem_read = rd_en; ex_mem_write = wr_en;
    ex_mem_to_reg = m2r;  ex_mem_size = size;  ex_mem_unsigned = uns;
    #1;
  endtask

  task automatic nop();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
    nop();
    #1;
    check("rst_wb_result", wb_result, 32'h0);
    check("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
    check("rst_wb_we", {31'b0, wb_reg_write}, 32'h0);
    check("rst_fault", {31'b0, misalign_fault}, 32'h0);
    check("rst_req_valid", {31'b0, dmem_req_valid}, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // ADD-type: single-cycle writeback, no stall
    set_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    check("add_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    check("add_wb_result", wb_result, 32'h1234);
    check("add_wb_rd", {27'b0, wb_rd}, 32'd5);
    check("add_wb_we", {31'b0, wb_reg_write}, 32'h1);

    // SB 0x103, ready immediately: one stall cycle, top-lane strobe
    dmem_req_ready = 1'b1;
    set_op(32'h103, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("sb_idle_stall", {31'b0, mem_stall}, 32'h1);
    check("sb_idle_noreq", {31'b0, dmem_req_valid}, 32'h0);
    tick();
    check("sb_req_valid", {31'b0, dmem_req_valid}, 32'h1);
    check("sb_addr", dmem_addr, 32'h100);
    check("sb_we", {31'b0, dmem_we}, 32'h1);
    check("sb_wstrb", {28'b0, dmem_wstrb}, 32'h8);
    check("sb_wdata", dmem_wdata, 32'hABABABAB);
    check("sb_req_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    check("sb_done_noreq", {31'b0, dmem_req_valid}, 32'h0);
    check("sb_wb_we", {31'b0, wb_reg_write}, 32'h0);

    // SH 0x102: upper halfword lanes
    set_op(32'h102, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    tick();
    check("sh_wstrb", {28'b0, dmem_wstrb}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'h56785678);
    tick();

    // LB 0x101, one not-ready cycle, response 3 cycles late
    dmem_req_ready = 1'b0;
    set_op(32'h101, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    check("lb_idle_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    check("lb_req_valid", {31'b0, dmem_req_valid}, 32'h1);
    check("lb_we", {31'b0, dmem_we}, 32'h0);
    check("lb_wstrb", {28'b0, dmem_wstrb}, 32'h0);
    check("lb_notready_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    check("lb_req_held", {31'b0, dmem_req_valid}, 32'h1);
    check("lb_addr_held", dmem_addr, 32'h100);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    #1;
    check("lb_wait_noreq", {31'b0, dmem_req_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("lb_wait_stall", {31'b0, mem_stall}, 32'h1);
      tick();
    end
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0000_8000;
    #1;
    check("lb_rsp_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    dmem_rsp_valid = 1'b0;
    check("lb_wb_result", wb_result, 32'hFFFFFF80);
    check("lb_wb_rd", {27'b0, wb_rd}, 32'd7);
    check("lb_wb_we", {31'b0, wb_reg_write}, 32'h1);

    // LHU 0x102: zero-extended upper halfword
    dmem_req_ready = 1'b1;
    set_op(32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    tick(); tick();
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hBEEF_0000;
    tick();
    dmem_rsp_valid = 1'b0;
    check("lhu_wb_result", wb_result, 32'h0000BEEF);
    check("lhu_wb_rd", {27'b0, wb_rd}, 32'd9);

    // LW 0x104 aligned word
    set_op(32'h104, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    tick(); tick();
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rsp_valid = 1'b0;
    check("lw_wb_result", wb_result, 32'hCAFEF00D);

    // LW 0x102 misaligned: no request, one-cycle fault pulse
    set_op(32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    check("mis_stall", {31'b0, mem_stall}, 32'h0);
    check("mis_noreq", {31'b0, dmem_req_valid}, 32'h0);
    tick();
    check("mis_fault", {31'b0, misalign_fault}, 32'h1);
    check("mis_wb_we", {31'b0, wb_reg_write}, 32'h0);
    check("mis_wb_rd", {27'b0, wb_rd}, 32'd3);
    check("mis_noreq2", {31'b0, dmem_req_valid}, 32'h0);
    nop();
    tick();
    check("mis_fault_clr", {31'b0, misalign_fault}, 32'h0);

    // Reset while in WAIT, then a late response must be ignored
    set_op(32'h200, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rstw_wb_result", wb_result, 32'h0);
    check("rstw_wb_we", {31'b0, wb_reg_write}, 32'h0);
    check("rstw_req_valid", {31'b0, dmem_req_valid}, 32'h0);
    tick();
    rst = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    check("rstw_idle_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    check("rstw_req_after", {31'b0, dmem_req_valid}, 32'h1);
    check("rstw_wb_hold", wb_result, 32'h0);
    check("rstw_wb_we_hold", {31'b0, wb_reg_write}, 32'h0);
    dmem_rsp_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
